reg_cmd_bridge: RTL and testbench

//  Byte-stream command decoder that masters the 4 x 8-bit device register bank.

---
 rtl/reg_cmd_bridge_pkg.sv | 35 +++
 rtl/reg_cmd_bridge_if.sv | 26 ++
 rtl/reg_cmd_bridge.sv | 125 ++++++++++++
 tb/tb_reg_cmd_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_bridge_pkg.sv
// Shared definitions for the register-bank command bridge: FSM encoding,
// command byte field positions and default response codes.
package reg_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GETD = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_CAP  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [7:0] DEF_ACK_CODE = 8'hA5;
  localparam logic [7:0] DEF_ERR_CODE = 8'hEE;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

  function automatic logic cmd_rsv_bad(input logic [7:0] cmd);
    return |cmd[CMD_RSV_HI:CMD_RSV_LO];
  endfunction

  function automatic logic [3:0] cmd_addr(input logic [7:0] cmd);
    return cmd[CMD_ADDR_HI:CMD_ADDR_LO];
  endfunction

endpackage

// File: rtl/reg_cmd_bridge_if.sv
// Bundle of the command stream, response stream and register-bank access bus.
// Handshake: a byte moves on a rising clk edge where valid & ready are both high;
// the producer holds valid and data stable until that edge, ready may toggle freely.
interface reg_cmd_bridge_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] address;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;
  logic [7:0] read_data;

  modport master (
    input  cmd_valid, cmd_data, rsp_ready, read_data,
    output cmd_ready, rsp_valid, rsp_data, address, write_en, read_en, data_in
  );

  modport slave (
    output cmd_valid, cmd_data, rsp_ready, read_data,
    input  cmd_ready, rsp_valid, rsp_data, address, write_en, read_en, data_in
  );
endinterface

// File: rtl/reg_cmd_bridge.sv
// Byte-stream command decoder mastering a small register bank; one command
// outstanding at a time, one response byte per command, all outputs registered.
module reg_cmd_bridge
  import reg_cmd_pkg::*;
#(
  parameter int         NUM_REGS = 4,
  parameter logic [7:0] ACK_CODE = DEF_ACK_CODE,
  parameter logic [7:0] ERR_CODE = DEF_ERR_CODE
) (
  input  logic                 clk,
  input  logic                 resetb,
  reg_cmd_bridge_if.master     bus,
  output state_t               o_state
);

  state_t     r_state;
  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic [3:0] r_address;
  logic       r_write_en;
  logic       r_read_en;
  logic [7:0] r_data_in;
  logic [3:0] r_cmd_addr;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_new_addr_ok;
  logic w_held_addr_ok;

  assign w_cmd_fire     = bus.cmd_valid & r_cmd_ready;
  assign w_rsp_fire     = r_rsp_valid & bus.rsp_ready;
  assign w_new_addr_ok  = int'(cmd_addr(bus.cmd_data)) < NUM_REGS;
  assign w_held_addr_ok = int'(r_cmd_addr) < NUM_REGS;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_address   <= 4'h0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_data_in   <= 8'h00;
      r_cmd_addr  <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // cmd_ready comes up one edge after reset release and after each response
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_cmd_addr <= cmd_addr(bus.cmd_data);
            if (cmd_rsv_bad(bus.cmd_data) ||
                (!cmd_is_write(bus.cmd_data) && !w_new_addr_ok)) begin
              r_cmd_ready <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= ERR_CODE;
              r_state     <= ST_RESP;
            end else if (cmd_is_write(bus.cmd_data)) begin
              r_state     <= ST_GETD;
            end else begin
              r_cmd_ready <= 1'b0;
              r_address   <= cmd_addr(bus.cmd_data);
              r_read_en   <= 1'b1;
              r_state     <= ST_RD;
            end
          end
        end
        ST_GETD: begin
          if (w_cmd_fire) begin
            r_cmd_ready <= 1'b0;
            // Out-of-range write still swallows its data byte so the stream stays aligned
            if (!w_held_addr_ok) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= ERR_CODE;
              r_state     <= ST_RESP;
            end else begin
              r_address   <= r_cmd_addr;
              r_data_in   <= bus.cmd_data;
              r_write_en  <= 1'b1;
              r_state     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          r_write_en  <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= ACK_CODE;
          r_state     <= ST_RESP;
        end
        ST_RD: begin
          r_read_en <= 1'b0;
          r_state   <= ST_CAP;
        end
        ST_CAP: begin
          // The bank registers its read port, so data lands one cycle after read_en
          r_rsp_data  <= bus.read_data;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.address   = r_address;
  assign bus.write_en  = r_write_en;
  assign bus.read_en   = r_read_en;
  assign bus.data_in   = r_data_in;
  assign o_state       = r_state;

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Bench for reg_cmd_bridge: table of single commands, then hand sequences for
// latency, backpressure, reset mid-command and a throttled stream.
module tb_reg_cmd_bridge;
  import reg_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk;
  logic   resetb;
  state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_cmd_bridge_if bus();

  reg_cmd_bridge dut (
    .clk     (clk),
    .resetb  (resetb),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- register bank model ----------------
  logic [7:0] mem [4];
  logic [7:0] rd_q;
  int         wr_cnt;
  int         rd_cnt;
  int         checks;
  int         errors;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    rd_q   = 8'h00;
    wr_cnt = 0;
    rd_cnt = 0;
  end

  always @(posedge clk) begin
    if (bus.write_en) begin
      mem[bus.address[1:0]] <= bus.data_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.read_en) begin
      rd_q   <= mem[bus.address[1:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.write_en && bus.read_en) begin
      errors <= errors + 1;
      $display("FAIL wr_rd_overlap: write_en=1 read_en=1 required not both");
    end
  end

  assign bus.read_data = rd_q;

  // ---------------- scoreboard / helpers ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0 after 200 cycles required 1");
    end else begin
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [7:0] d);
    int n;
    n = 0;
    d = 8'hxx;
    bus.rsp_ready = 1'b1;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL rsp_timeout: got rsp_valid=0 after 200 cycles required 1");
    end else begin
      d = bus.rsp_data;
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] cmd;
    logic       has_data;
    logic [7:0] dat;
    logic [7:0] exp_rsp;
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [7:0] d;
    logic [7:0] m3;
    logic [7:0] sdat [4];
    int wr0;
    int rd0;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'h82, 1'b1, 8'h3C, 8'hA5, 1, 0};
    vecs[1] = '{8'h02, 1'b0, 8'h00, 8'h3C, 0, 1};
    vecs[2] = '{8'h95, 1'b0, 8'h00, 8'hEE, 0, 0};
    vecs[3] = '{8'h87, 1'b1, 8'h11, 8'hEE, 0, 0};
    vecs[4] = '{8'h06, 1'b0, 8'h00, 8'hEE, 0, 0};
    vecs[5] = '{8'h81, 1'b1, 8'h5A, 8'hA5, 1, 0};
    vecs[6] = '{8'h01, 1'b0, 8'h00, 8'h5A, 0, 1};
    vecs[7] = '{8'h70, 1'b0, 8'h00, 8'hEE, 0, 0};
    vecs[8] = '{8'h8F, 1'b1, 8'hFF, 8'hEE, 0, 0};

    // reset state
    resetb        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    tick(2);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outs", {bus.cmd_ready, bus.rsp_valid, bus.write_en, bus.read_en},
          4'b0000);
    check("rst_buses", {bus.address, bus.data_in, bus.rsp_data}, 20'h0);
    resetb = 1'b1;
    #1;
    check("rst_rel_ready_low", bus.cmd_ready, 1'b0);
    tick(1);
    check("rst_rel_ready_high", bus.cmd_ready, 1'b1);

    // table-driven single commands
    for (int i = 0; i < 9; i++) begin
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      put_byte(vecs[i].cmd);
      if (vecs[i].has_data) put_byte(vecs[i].dat);
      get_rsp(d);
      tick(1);
      check($sformatf("vec%0d_rsp", i), d, vecs[i].exp_rsp);
      check($sformatf("vec%0d_wr", i), wr_cnt - wr0, vecs[i].exp_wr);
      check($sformatf("vec%0d_rd", i), rd_cnt - rd0, vecs[i].exp_rd);
    end
    check("bank_reg2", mem[2], 8'h3C);
    check("bank_reg1", mem[1], 8'h5A);

    // write latency: data accepted at T, write_en in T+1, rsp_valid in T+2
    bus.rsp_ready = 1'b1;
    put_byte(8'h80);
    put_byte(8'h0D);
    check("wlat_t1_we", {bus.write_en, bus.read_en}, 2'b10);
    check("wlat_t1_bus", {bus.address, bus.data_in}, {4'h0, 8'h0D});
    tick(1);
    check("wlat_t2", {bus.write_en, bus.rsp_valid, bus.rsp_data}, {2'b01, 8'hA5});
    tick(1);
    check("wlat_t3", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    check("wlat_bank", mem[0], 8'h0D);

    // read latency: accept at T, read_en in T+1, rsp_valid in T+3
    put_byte(8'h02);
    check("rlat_t1", {bus.read_en, bus.write_en, bus.address}, {2'b10, 4'h2});
    tick(1);
    check("rlat_t2", {bus.read_en, bus.rsp_valid}, 2'b00);
    tick(1);
    check("rlat_t3", {bus.rsp_valid, bus.rsp_data}, {1'b1, 8'h3C});
    tick(1);
    check("rlat_t4", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    bus.rsp_ready = 1'b0;

    // backpressure on a read of reg1
    rd0 = rd_cnt;
    put_byte(8'h01);
    for (int n = 0; n < 10 && bus.rsp_valid !== 1'b1; n++) tick(1);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("bp_hold%0d", n), {bus.rsp_valid, bus.cmd_ready, bus.rsp_data},
            {2'b10, 8'h5A});
      tick(1);
    end
    check("bp_rd_once", rd_cnt - rd0, 1);
    get_rsp(d);
    check("bp_rsp", d, 8'h5A);
    check("bp_rd_once_after", rd_cnt - rd0, 1);

    // reset while waiting for the data byte
    m3  = mem[3];
    wr0 = wr_cnt;
    put_byte(8'h83);
    check("rm_getd", dbg_state, ST_GETD);
    resetb = 1'b0;
    #1;
    check("rm_getd_outs", {bus.cmd_ready, bus.rsp_valid, bus.write_en, bus.read_en,
                           bus.address, bus.data_in, bus.rsp_data}, 0);
    check("rm_getd_state", dbg_state, ST_IDLE);
    tick(1);
    resetb = 1'b1;
    tick(1);
    check("rm_getd_ready", bus.cmd_ready, 1'b1);

    // reset while write_en is high
    put_byte(8'h83);
    put_byte(8'h77);
    check("rm_wr_pulse", bus.write_en, 1'b1);
    resetb = 1'b0;
    #1;
    check("rm_wr_drop", {bus.write_en, bus.cmd_ready, bus.rsp_valid}, 3'b000);
    tick(1);
    resetb = 1'b1;
    tick(1);
    check("rm_wr_ready", bus.cmd_ready, 1'b1);
    tick(2);
    check("rm_bank_untouched", mem[3], m3);
    check("rm_no_write", wr_cnt - wr0, 0);

    // throttled stream: 4 writes then 4 reads
    sdat[0] = 8'hC3;
    sdat[1] = 8'h18;
    sdat[2] = 8'h7E;
    sdat[3] = 8'h42;
    for (int i = 0; i < 8; i++) begin
      tick($urandom_range(0, 3));
      if (i < 4) begin
        put_byte(8'h80 | 8'(i));
        tick($urandom_range(0, 3));
        put_byte(sdat[i]);
        exp_q.push_back(8'hA5);
      end else begin
        put_byte(8'(i - 4));
        exp_q.push_back(sdat[i - 4]);
      end
      tick($urandom_range(0, 4));
      get_rsp(d);
      check($sformatf("stream%0d", i), d, exp_q.pop_front());
    end
    check("stream_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
